// File: rtl/vm_param_ctrl_if.sv
// vm_param_ctrl_if
// Bundles the coin/cancel strobes and the vend/change/status outputs of the
// vending controller. The controller has no valid/ready handshake: D_in and
// Cancel are single-cycle strobes sampled on every rising clock edge, and the
// outputs are plain status/pulse signals with no backpressure.
//
// Signals:
//   D_in      coin strobes (bit 0 = coin 0, bit 1 = coin 1)
//   Cancel    refund request strobe
//   D_out     vend pulse, one cycle per item
//   D_C       change pulse, one cycle per returned unit
//   Credit    current credit in change units
//   Busy      high while vending or paying change
//   Coin_rej  one-cycle pulse after a coin arrived while busy
//   state_dbg current FSM state, for observation only
interface vm_param_ctrl_if #(
    parameter int W = 4
);
    logic [1:0]   D_in;
    logic         Cancel;
    logic         D_out;
    logic         D_C;
    logic [W-1:0] Credit;
    logic         Busy;
    logic         Coin_rej;
    logic [1:0]   state_dbg;

    modport master (
        output D_in, Cancel,
        input  D_out, D_C, Credit, Busy, Coin_rej, state_dbg
    );

    modport slave (
        input  D_in, Cancel,
        output D_out, D_C, Credit, Busy, Coin_rej, state_dbg
    );
endinterface

// File: rtl/vm_param_ctrl.sv
// vm_param_ctrl
// Parametrised vending controller. Coins add to a credit register; when the
// credit reaches PRICE the block vends for one cycle, then pays the remainder
// back as single-unit change pulses. Cancel refunds the whole credit as change.
//
// Ports:
//   Clk    system clock, rising edge
//   Reset  asynchronous, active-low reset
//   bus    vm_param_ctrl_if slave modport (coin/cancel in, vend/change/status out)
//
// Parameters (all in change units):
//   W          credit register width
//   PRICE      item price, 1..2^W-1
//   COIN0_VAL  value of a D_in[0] coin
//   COIN1_VAL  value of a D_in[1] coin
module vm_param_ctrl #(
    parameter int W         = 4,
    parameter int PRICE     = 3,
    parameter int COIN0_VAL = 1,
    parameter int COIN1_VAL = 2
) (
    input  logic         Clk,
    input  logic         Reset,
    vm_param_ctrl_if.slave bus
);

    // The largest credit ever held is PRICE-1 plus both coins at once; if that
    // does not fit in W bits the credit register could wrap.
    if (PRICE < 1 || PRICE > (2**W) - 1 ||
        PRICE - 1 + COIN0_VAL + COIN1_VAL > (2**W) - 1) begin : g_illegal_params
        $error("vm_param_ctrl: illegal PRICE/COIN values for W");
    end

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        VEND    = 2'd1,
        CHANGE  = 2'd2
    } state_t;

    localparam logic [W:0] PRICE_W = (W+1)'(PRICE);
    localparam logic [W:0] COIN0_W = (W+1)'(COIN0_VAL);
    localparam logic [W:0] COIN1_W = (W+1)'(COIN1_VAL);

    state_t       state_q, state_d;
    logic [W-1:0] credit_q, credit_d;
    logic         rej_q, rej_d;
    logic [W:0]   add;
    logic [W:0]   sum;

    assign add = (bus.D_in[0] ? COIN0_W : '0) + (bus.D_in[1] ? COIN1_W : '0);
    assign sum = {1'b0, credit_q} + add;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= COLLECT;
            credit_q <= '0;
            rej_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            rej_q    <= rej_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        rej_d    = 1'b0;
        case (state_q)
            COLLECT: begin
                credit_d = sum[W-1:0];
                // Cancel wins over a vend; a cancel with nothing to refund is dropped.
                if (bus.Cancel && sum != '0) begin
                    state_d = CHANGE;
                end else if (sum >= PRICE_W) begin
                    state_d = VEND;
                end
            end
            VEND: begin
                credit_d = credit_q - PRICE_W[W-1:0];
                state_d  = (credit_q > PRICE_W[W-1:0]) ? CHANGE : COLLECT;
                rej_d    = |bus.D_in;
            end
            CHANGE: begin
                if (credit_q == W'(1)) begin
                    // Edge ending the last change pulse already behaves as
                    // COLLECT from zero credit: a coin here is credited.
                    credit_d = add[W-1:0];
                    state_d  = (add >= PRICE_W) ? VEND : COLLECT;
                end else begin
                    credit_d = credit_q - W'(1);
                    rej_d    = |bus.D_in;
                end
            end
            default: begin
                state_d  = COLLECT;
                credit_d = '0;
            end
        endcase
    end

    // Outputs are decoded from registers only, so reset clears them at once.
    assign bus.D_out     = (state_q == VEND);
    assign bus.D_C       = (state_q == CHANGE);
    assign bus.Busy      = (state_q == VEND) || (state_q == CHANGE);
    assign bus.Coin_rej  = rej_q;
    assign bus.Credit    = credit_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_vm_param_ctrl.sv
module tb_vm_param_ctrl;

    logic Clk;
    logic Reset;

    vm_param_ctrl_if #(.W(4)) if0 ();
    vm_param_ctrl_if #(.W(4)) if1 ();

    // Default configuration: price 3, coins 1 and 2.
    vm_param_ctrl #(.W(4), .PRICE(3), .COIN0_VAL(1), .COIN1_VAL(2)) dut0 (
        .Clk(Clk), .Reset(Reset), .bus(if0)
    );
    // Alternate configuration: price 5, coins 1 and 4.
    vm_param_ctrl #(.W(4), .PRICE(5), .COIN0_VAL(1), .COIN1_VAL(4)) dut1 (
        .Clk(Clk), .Reset(Reset), .bus(if1)
    );

    // ---------------- clock / reset ----------------
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each instance is modelled as a credit value plus a schedule of busy
    // cycles still to come: vend_q cycles of vending followed by chg_q cycles
    // of change. Outputs follow from whatever the schedule's head is.
    int m0_credit, m0_vend, m0_chg, m0_rej;
    int m1_credit, m1_vend, m1_chg, m1_rej;

    task automatic model_collect(input int price, input int add, input bit cancel_ok,
                                 input bit cancel, inout int credit,
                                 inout int vend_q, inout int chg_q);
        credit = credit + add;
        if (cancel_ok && cancel && credit > 0) begin
            chg_q = credit;
        end else if (credit >= price) begin
            vend_q = 1;
            chg_q  = credit - price;
        end
    endtask

    task automatic model_step(input int price, input int c0, input int c1,
                              input logic [1:0] din, input logic cancel,
                              inout int credit, inout int vend_q,
                              inout int chg_q, inout int rej);
        int add;
        add = (din[0] ? c0 : 0) + (din[1] ? c1 : 0);
        if (vend_q > 0) begin
            vend_q = 0;
            credit = credit - price;
            rej    = (din != 0);
        end else if (chg_q > 0) begin
            chg_q  = chg_q - 1;
            credit = credit - 1;
            if (chg_q == 0) begin
                rej = 0;
                model_collect(price, add, 1'b0, cancel, credit, vend_q, chg_q);
            end else begin
                rej = (din != 0);
            end
        end else begin
            rej = 0;
            model_collect(price, add, 1'b1, cancel, credit, vend_q, chg_q);
        end
    endtask

    task automatic model_reset();
        m0_credit = 0; m0_vend = 0; m0_chg = 0; m0_rej = 0;
        m1_credit = 0; m1_vend = 0; m1_chg = 0; m1_rej = 0;
    endtask

    task automatic check_models();
        check("m0 Credit",   int'(if0.Credit),   m0_credit);
        check("m0 D_out",    int'(if0.D_out),    int'(m0_vend > 0));
        check("m0 D_C",      int'(if0.D_C),      int'(m0_vend == 0 && m0_chg > 0));
        check("m0 Busy",     int'(if0.Busy),     int'(m0_vend + m0_chg > 0));
        check("m0 Coin_rej", int'(if0.Coin_rej), m0_rej);
        check("m1 Credit",   int'(if1.Credit),   m1_credit);
        check("m1 D_out",    int'(if1.D_out),    int'(m1_vend > 0));
        check("m1 D_C",      int'(if1.D_C),      int'(m1_vend == 0 && m1_chg > 0));
        check("m1 Busy",     int'(if1.Busy),     int'(m1_vend + m1_chg > 0));
        check("m1 Coin_rej", int'(if1.Coin_rej), m1_rej);
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input logic [1:0] din, input logic cancel);
        if0.D_in = din; if0.Cancel = cancel;
        if1.D_in = din; if1.Cancel = cancel;
        @(posedge Clk);
        #1;
        if0.D_in = 2'b00; if0.Cancel = 1'b0;
        if1.D_in = 2'b00; if1.Cancel = 1'b0;
        model_step(3, 1, 2, din, cancel, m0_credit, m0_vend, m0_chg, m0_rej);
        model_step(5, 1, 4, din, cancel, m1_credit, m1_vend, m1_chg, m1_rej);
        check_models();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " Credit"},   int'(if0.Credit),   0);
        check({tag, " D_out"},    int'(if0.D_out),    0);
        check({tag, " D_C"},      int'(if0.D_C),      0);
        check({tag, " Busy"},     int'(if0.Busy),     0);
        check({tag, " Coin_rej"}, int'(if0.Coin_rej), 0);
        check({tag, " m1 Credit"}, int'(if1.Credit),  0);
        check({tag, " m1 Busy"},   int'(if1.Busy),    0);
    endtask

    // Reset asserted asynchronously a few ns after an edge, held 3 cycles,
    // released away from the active edge.
    task automatic async_reset();
        #2 Reset = 1'b0;
        #1 check_all_zero("async reset");
        repeat (3) @(posedge Clk);
        #1 check_all_zero("held reset");
        @(negedge Clk);
        Reset = 1'b1;
        model_reset();
    endtask

    // ---------------- directed vector table (default config) ----------------
    typedef struct {
        logic [1:0] din;
        logic       cancel;
        int         credit;
        logic       dout;
        logic       dc;
        logic       busy;
        logic       rej;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [1:0] din, input logic cancel, input int credit,
                                input logic dout, input logic dc, input logic busy,
                                input logic rej);
        vec_t v;
        v.din = din; v.cancel = cancel; v.credit = credit;
        v.dout = dout; v.dc = dc; v.busy = busy; v.rej = rej;
        return v;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        logic [1:0] rdin;
        logic       rcan;
        int         dc_count;

        Reset = 1'b0;
        if0.D_in = 2'b00; if0.Cancel = 1'b0;
        if1.D_in = 2'b00; if1.Cancel = 1'b0;
        model_reset();

        // Exact price: three 0.5 coins
        tbl.push_back(mk(2'b01, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(2'b01, 0, 2, 0, 0, 0, 0));
        tbl.push_back(mk(2'b01, 0, 3, 1, 0, 1, 0));
        tbl.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0));
        // Overpayment: 1.0, idle, 1.0
        tbl.push_back(mk(2'b10, 0, 2, 0, 0, 0, 0));
        tbl.push_back(mk(2'b00, 0, 2, 0, 0, 0, 0));
        tbl.push_back(mk(2'b10, 0, 4, 1, 0, 1, 0));
        tbl.push_back(mk(2'b00, 0, 1, 0, 1, 1, 0));
        tbl.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0));
        // Both coins with credit 2
        tbl.push_back(mk(2'b10, 0, 2, 0, 0, 0, 0));
        tbl.push_back(mk(2'b11, 0, 5, 1, 0, 1, 0));
        tbl.push_back(mk(2'b00, 0, 2, 0, 1, 1, 0));
        tbl.push_back(mk(2'b00, 0, 1, 0, 1, 1, 0));
        tbl.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0));
        // Cancel with credit 2
        tbl.push_back(mk(2'b10, 0, 2, 0, 0, 0, 0));
        tbl.push_back(mk(2'b00, 1, 2, 0, 1, 1, 0));
        tbl.push_back(mk(2'b00, 0, 1, 0, 1, 1, 0));
        tbl.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0));
        // Cancel with zero credit is ignored
        tbl.push_back(mk(2'b00, 1, 0, 0, 0, 0, 0));
        // Cancel together with a completing coin refunds credit_next
        tbl.push_back(mk(2'b10, 0, 2, 0, 0, 0, 0));
        tbl.push_back(mk(2'b01, 1, 3, 0, 1, 1, 0));
        tbl.push_back(mk(2'b00, 0, 2, 0, 1, 1, 0));
        tbl.push_back(mk(2'b00, 0, 1, 0, 1, 1, 0));
        tbl.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0));
        // Coins during VEND and mid-CHANGE are rejected
        tbl.push_back(mk(2'b10, 0, 2, 0, 0, 0, 0));
        tbl.push_back(mk(2'b11, 0, 5, 1, 0, 1, 0));
        tbl.push_back(mk(2'b01, 0, 2, 0, 1, 1, 1));
        tbl.push_back(mk(2'b01, 0, 1, 0, 1, 1, 1));
        tbl.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0));
        // Coin on the edge ending the last change pulse is credited
        tbl.push_back(mk(2'b10, 0, 2, 0, 0, 0, 0));
        tbl.push_back(mk(2'b10, 0, 4, 1, 0, 1, 0));
        tbl.push_back(mk(2'b00, 0, 1, 0, 1, 1, 0));
        tbl.push_back(mk(2'b10, 0, 2, 0, 0, 0, 0));
        tbl.push_back(mk(2'b01, 0, 3, 1, 0, 1, 0));
        tbl.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0));
        // Cancel while busy is ignored
        tbl.push_back(mk(2'b10, 0, 2, 0, 0, 0, 0));
        tbl.push_back(mk(2'b10, 0, 4, 1, 0, 1, 0));
        tbl.push_back(mk(2'b00, 1, 1, 0, 1, 1, 0));
        tbl.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0));

        // Reset state
        repeat (2) @(posedge Clk);
        #1 check_all_zero("reset state");
        @(negedge Clk);
        Reset = 1'b1;

        // Directed table, default config
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].din, tbl[i].cancel);
            check($sformatf("vec%0d Credit", i),   int'(if0.Credit),   tbl[i].credit);
            check($sformatf("vec%0d D_out", i),    int'(if0.D_out),    int'(tbl[i].dout));
            check($sformatf("vec%0d D_C", i),      int'(if0.D_C),      int'(tbl[i].dc));
            check($sformatf("vec%0d Busy", i),     int'(if0.Busy),     int'(tbl[i].busy));
            check($sformatf("vec%0d Coin_rej", i), int'(if0.Coin_rej), int'(tbl[i].rej));
        end

        // Reset mid-CHANGE with Credit=2, then the next coin credits from 0
        step(2'b10, 1'b0);
        step(2'b11, 1'b0);
        step(2'b00, 1'b0);
        check("pre-reset Credit", int'(if0.Credit), 2);
        check("pre-reset D_C",    int'(if0.D_C),    1);
        async_reset();
        step(2'b01, 1'b0);
        check("post-reset Credit", int'(if0.Credit), 1);
        check("post-reset Busy",   int'(if0.Busy),   0);
        step(2'b00, 1'b1);   // refund the unit to return to zero
        step(2'b00, 1'b0);
        check("refund done Credit", int'(if0.Credit), 0);

        // Alternate config: two 1.0 coins (4 units each) -> credit 8, vend, 3 change
        async_reset();
        step(2'b10, 1'b0);
        check("alt Credit 4", int'(if1.Credit), 4);
        step(2'b10, 1'b0);
        check("alt Credit 8", int'(if1.Credit), 8);
        check("alt D_out",    int'(if1.D_out),  1);
        dc_count = 0;
        for (int i = 0; i < 6; i++) begin
            step(2'b00, 1'b0);
            if (if1.D_C) dc_count++;
        end
        check("alt D_C count", dc_count, 3);
        check("alt final Credit", int'(if1.Credit), 0);

        // Randomized stimulus against the reference model, both configs
        for (int i = 0; i < 2000; i++) begin
            rdin = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            rcan = ($urandom_range(0, 9) == 0);
            step(rdin, rcan);
            if (i == 1000) async_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
